// File: rtl/alu_logic_arbiter.sv
// alu_logic_arbiter: shares one AND/XOR/OR/NOT-B logic unit between two
// valid/ready requesters. Grants are round-robin. The operands of an accepted
// request are captured, executed one cycle later, and the result is held
// tagged with the requester id until the consumer takes it.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req{0,1}_valid/_ready      request handshake (ready is combinational, IDLE only)
//   req{0,1}_a/_b              operands, WIDTH bits
//   req{0,1}_op                opcode {s2,s3}: 00 AND, 01 XOR, 10 OR, 11 NOT B
//   res_valid/res_ready        result handshake
//   res_data/res_id/res_zero   registered result, issuing requester, zero flag
//   busy                       FSM is not in IDLE
//   op_count                   completed results, wraps at 2^CNT_W
module alu_logic_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             res_zero,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Captured request payload
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             id;
  } op_reg_t;

  state_t     state_q;
  state_t     state_d;
  logic       last_grant_q;
  op_reg_t    op_q;
  logic       accept_c;
  logic       accept_id_c;
  logic [WIDTH-1:0] lu_y_c;

  // Shared logic unit; s2 = op[1], s3 = op[0]
  function automatic logic [WIDTH-1:0] logic_unit(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             s2,
    input logic             s3
  );
    logic [WIDTH-1:0] y;
    unique case ({s2, s3})
      2'b00:   y = a & b;
      2'b01:   y = a ^ b;
      2'b10:   y = a | b;
      default: y = ~b;
    endcase
    return y;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_c) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant and status outputs; on contention the requester not served last wins
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    busy       = (state_q != IDLE);
    if (state_q == IDLE) begin
      req0_ready = req0_valid & (~req1_valid | last_grant_q);
      req1_ready = req1_valid & (~req0_valid | ~last_grant_q);
    end
  end

  assign accept_c    = req0_ready | req1_ready;
  assign accept_id_c = req1_ready;
  assign lu_y_c      = logic_unit(op_q.a, op_q.b, op_q.op[1], op_q.op[0]);

  // Operand capture, result register and completion counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= '0;
      last_grant_q <= 1'b1;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_id       <= 1'b0;
      res_zero     <= 1'b0;
      op_count     <= '0;
    end else begin
      if (accept_c) begin
        op_q.a       <= accept_id_c ? req1_a  : req0_a;
        op_q.b       <= accept_id_c ? req1_b  : req0_b;
        op_q.op      <= accept_id_c ? req1_op : req0_op;
        op_q.id      <= accept_id_c;
        last_grant_q <= accept_id_c;
      end
      if (state_q == EXEC) begin
        res_data  <= lu_y_c;
        res_zero  <= (lu_y_c == '0);
        res_id    <= op_q.id;
        res_valid <= 1'b1;
      end
      // res_ready outside DONE has no effect
      if ((state_q == DONE) && res_valid && res_ready) begin
        res_valid <= 1'b0;
        op_count  <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_logic_arbiter.sv
// Directed bench for alu_logic_arbiter (WIDTH=8, CNT_W=4 so wrap is reachable).
module tb_alu_logic_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready;
  logic [7:0] req0_a, req0_b;
  logic [1:0] req0_op;
  logic       req1_valid, req1_ready;
  logic [7:0] req1_a, req1_b;
  logic [1:0] req1_op;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic       res_id, res_zero, busy;
  logic [3:0] op_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_cnt;

  alu_logic_arbiter #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .res_zero(res_zero),
    .busy(busy), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lu(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a ^ b;
      2'b10:   return a | b;
      default: return ~b;
    endcase
  endfunction

  // One complete transaction with res_ready held high; operands are scrambled after accept.
  task automatic do_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op, input logic [7:0] exp);
    int w;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    #1;
    w = 0;
    while (!(id ? req1_ready : req0_ready) && w < 5) begin
      tick();
      w++;
    end
    chk("grant", 32'(id ? req1_ready : req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~a; req0_b = ~b; req0_op = ~op;
    req1_a = ~a; req1_b = ~b; req1_op = ~op;
    chk("exec_valid", 32'(res_valid), 32'd0);
    chk("exec_busy", 32'(busy), 32'd1);
    tick();
    chk("res_valid", 32'(res_valid), 32'd1);
    chk("res_data", 32'(res_data), 32'(exp));
    chk("res_id", 32'(res_id), 32'(id));
    chk("res_zero", 32'(res_zero), 32'(exp == 8'h00));
    tick();
    exp_cnt = exp_cnt + 4'd1;
    chk("op_count", 32'(op_count), 32'(exp_cnt));
    chk("done_valid", 32'(res_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; res_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    exp_cnt = '0;
    tick(); tick();
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    chk("rst_data", 32'(res_data), 32'd0);
    chk("rst_id", 32'(res_id), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single op on requester 0
    res_ready = 1'b1;
    do_op(1'b0, 8'hF0, 8'h3C, 2'b00, 8'h30);

    // All opcodes on requester 1
    do_op(1'b1, 8'hA5, 8'h0F, 2'b01, 8'hAA);
    do_op(1'b1, 8'hA5, 8'h0F, 2'b10, 8'hAF);
    do_op(1'b1, 8'hA5, 8'h0F, 2'b11, 8'hF0);
    do_op(1'b1, 8'hA5, 8'h00, 2'b00, 8'h00);

    // Reset while an op is executing: no result may appear
    req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'hFF; req0_op = 2'b10;
    #1;
    tick();
    req0_valid = 1'b0;
    chk("t1_in_exec", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t1_async_busy", 32'(busy), 32'd0);
    chk("t1_async_count", 32'(op_count), 32'd0);
    tick();
    rst_n = 1'b1;
    exp_cnt = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_valid", 32'(res_valid), 32'd0);
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_count", 32'(op_count), 32'd0);
    end

    // Contention: both valid continuously, grants alternate starting with 0
    req0_a = 8'h11; req0_b = 8'h22; req0_op = 2'b10;
    req1_a = 8'h0F; req1_b = 8'hFF; req1_op = 2'b01;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("t4_r0", 32'(req0_ready), 32'(i % 2 == 0));
      chk("t4_r1", 32'(req1_ready), 32'(i % 2 == 1));
      tick();
      chk("t4_exec_rdy", 32'({req0_ready, req1_ready}), 32'd0);
      tick();
      chk("t4_done_rdy", 32'({req0_ready, req1_ready}), 32'd0);
      chk("t4_id", 32'(res_id), 32'(i % 2));
      chk("t4_data", 32'(res_data), (i % 2 == 0) ? 32'h33 : 32'hF0);
      tick();
      exp_cnt = exp_cnt + 4'd1;
      chk("t4_count", 32'(op_count), 32'(exp_cnt));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // res_ready with no result pending is ignored
    res_ready = 1'b1;
    tick(); tick();
    chk("idle_ready_count", 32'(op_count), 32'(exp_cnt));

    // Backpressure for 10 cycles in DONE
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h5A; req0_b = 8'hFF; req0_op = 2'b00;
    #1;
    chk("t5_grant", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0; req0_a = 8'h00;
    tick();
    req1_valid = 1'b1; req1_a = 8'h01; req1_b = 8'h02; req1_op = 2'b10;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t5_valid", 32'(res_valid), 32'd1);
      chk("t5_data", 32'(res_data), 32'h5A);
      chk("t5_id", 32'(res_id), 32'd0);
      chk("t5_rdy", 32'({req0_ready, req1_ready}), 32'd0);
      chk("t5_count", 32'(op_count), 32'(exp_cnt));
      tick();
    end
    req1_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    exp_cnt = exp_cnt + 4'd1;
    chk("t5_release_count", 32'(op_count), 32'(exp_cnt));
    chk("t5_release_valid", 32'(res_valid), 32'd0);
    tick(); tick();
    chk("t5_single_inc", 32'(op_count), 32'(exp_cnt));

    // Counter wrap: 17 completions from reset give op_count = 1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_cnt = '0;
    tick();
    for (int i = 0; i < 17; i++) begin
      logic [7:0] a, b;
      logic [1:0] op;
      a  = 8'(i * 37 + 5);
      b  = 8'(i * 11 + 3);
      op = 2'(i);
      do_op(1'(i % 2), a, b, op, lu(a, b, op));
    end
    chk("t6_wrap", 32'(op_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
